// File: rtl/adc_trigger.sv
// adc_trigger: trigger/capture stage between the ADC sampler and the
// waveform display renderer. Samples are recorded into a LEN-deep ring
// buffer. Once a level crossing is seen, one aligned frame of LEN samples
// (PRE of them ahead of the trigger sample) is streamed out over a
// valid/ready handshake.
//
// Optional feature macro: TRIG_AUTO_EN
//   When defined, an auto counter forces a trigger after AUTO_TO valid
//   samples in WAIT_TRIG (auto_en=1), and 'forced' flags such frames.
//   When undefined, auto_en is ignored and forced is tied to 0.
//
// Ports:
//   clkADC     sample clock, all logic on its rising edge
//   n_reset    asynchronous active-low reset
//   in_data    ADC sample, in_valid marks a new sample
//   level      unsigned trigger threshold
//   edge_sel   0 = rising crossing, 1 = falling crossing
//              ('edge' is a reserved word, hence the _sel name)
//   auto_en    enable auto trigger (TRIG_AUTO_EN builds only)
//   arm        start a capture, level-sensitive; held high = continuous
//   out_data / out_valid / out_last / out_ready   frame stream
//   busy       any state other than IDLE
//   forced     last frame was auto-triggered
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | waiting for arm, input ignored
// PREFILL   | recording the first PRE samples, crossings ignored
// WAIT_TRIG | recording and looking for a crossing
// POSTFILL  | recording the LEN-PRE-1 samples after the trigger
// READOUT   | streaming LEN samples starting at trigger address - PRE

module adc_trigger #(
    parameter int DN      = 10,
    parameter int ABITS   = 9,
    parameter int PRE     = 128,
    parameter int AUTO_TO = 65535
) (
    input  logic          clkADC,
    input  logic          n_reset,
    input  logic [DN-1:0] in_data,
    input  logic          in_valid,
    input  logic [DN-1:0] level,
    input  logic          edge_sel,
    input  logic          auto_en,
    input  logic          arm,
    output logic [DN-1:0] out_data,
    output logic          out_valid,
    output logic          out_last,
    input  logic          out_ready,
    output logic          busy,
    output logic          forced
);

    localparam int LEN  = 2**ABITS;
    localparam int POST = LEN - PRE - 1;

    localparam logic [ABITS-1:0] PRE_A  = ABITS'(PRE);
    localparam logic [ABITS-1:0] POST_A = ABITS'(POST);
    localparam logic [ABITS-1:0] A_ONE  = ABITS'(1);
    localparam logic [ABITS:0]   LEN_C  = (ABITS+1)'(LEN);
    localparam logic [ABITS:0]   C_ONE  = (ABITS+1)'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREFILL,
        S_WAIT_TRIG,
        S_POSTFILL,
        S_READOUT
    } state_t;

    state_t           state_q;
    logic [ABITS-1:0] wp_q;
    logic [ABITS-1:0] ra_q;
    logic [DN-1:0]    prev_q;
    logic [ABITS-1:0] pre_cnt_q;
    logic [ABITS-1:0] post_cnt_q;
    logic [ABITS:0]   rd_cnt_q;
    logic             rd_vld_q;
    logic             rd_last_q;
    logic [DN-1:0]    ram_rd_q;
    logic [DN-1:0]    out_data_q;
    logic             out_valid_q;
    logic             out_last_q;
    logic             busy_q;
    logic             forced_q;

    logic [DN-1:0]    mem_q [LEN];

    logic capture;
    logic wr_en;
    logic rise_hit;
    logic fall_hit;
    logic cross_hit;
    logic auto_hit;
    logic trig;
    logic s1_adv;
    logic out_fire;
    logic rd_en;

    assign capture   = (state_q == S_PREFILL) || (state_q == S_WAIT_TRIG) ||
                       (state_q == S_POSTFILL);
    assign wr_en     = in_valid && capture;
    assign rise_hit  = (prev_q < level) && (in_data >= level);
    assign fall_hit  = (prev_q > level) && (in_data <= level);
    assign cross_hit = edge_sel ? fall_hit : rise_hit;
    assign trig      = (state_q == S_WAIT_TRIG) && in_valid && (cross_hit || auto_hit);

    // Two-stage read pipeline: RAM output register, then output register.
    // The RAM register only reloads when its content moves on, so it acts
    // as the skid entry while the consumer stalls.
    assign out_fire = out_valid_q && out_ready;
    assign s1_adv   = rd_vld_q && (!out_valid_q || out_ready);
    assign rd_en    = (state_q == S_READOUT) && (rd_cnt_q != '0) && (!rd_vld_q || s1_adv);

`ifdef TRIG_AUTO_EN
    localparam int AW = $clog2(AUTO_TO + 1);
    localparam logic [AW-1:0] AUTO_LD  = AW'(AUTO_TO);
    localparam logic [AW-1:0] AUTO_ONE = AW'(1);
    logic [AW-1:0] auto_cnt_q;
    assign auto_hit = auto_en && (auto_cnt_q == AUTO_ONE);
`else
    logic unused_auto;
    assign auto_hit    = 1'b0;
    assign unused_auto = auto_en | (AUTO_TO < 1);
`endif

    always_ff @(posedge clkADC) begin
        if (wr_en) begin
            mem_q[wp_q] <= in_data;
        end
        if (rd_en) begin
            ram_rd_q <= mem_q[ra_q];
        end
    end

    always_ff @(posedge clkADC or negedge n_reset) begin
        if (!n_reset) begin
            state_q     <= S_IDLE;
            wp_q        <= '0;
            ra_q        <= '0;
            prev_q      <= '0;
            pre_cnt_q   <= '0;
            post_cnt_q  <= '0;
            rd_cnt_q    <= '0;
            rd_vld_q    <= 1'b0;
            rd_last_q   <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            forced_q    <= 1'b0;
`ifdef TRIG_AUTO_EN
            auto_cnt_q  <= '0;
`endif
        end else begin
            if (wr_en) begin
                wp_q   <= wp_q + A_ONE;
                prev_q <= in_data;
            end

            if (rd_en) begin
                ra_q      <= ra_q + A_ONE;
                rd_cnt_q  <= rd_cnt_q - C_ONE;
                rd_vld_q  <= 1'b1;
                rd_last_q <= (rd_cnt_q == C_ONE);
            end else if (s1_adv) begin
                rd_vld_q  <= 1'b0;
                rd_last_q <= 1'b0;
            end

            if (s1_adv) begin
                out_data_q  <= ram_rd_q;
                out_valid_q <= 1'b1;
                out_last_q  <= rd_last_q;
            end else if (out_fire) begin
                out_valid_q <= 1'b0;
                out_last_q  <= 1'b0;
            end

            unique case (state_q)
                S_IDLE: begin
                    if (arm) begin
                        state_q   <= S_PREFILL;
                        pre_cnt_q <= PRE_A;
                        busy_q    <= 1'b1;
                        forced_q  <= 1'b0;
                    end
                end
                S_PREFILL: begin
                    if (in_valid) begin
                        pre_cnt_q <= pre_cnt_q - A_ONE;
                        if (pre_cnt_q == A_ONE) begin
                            state_q <= S_WAIT_TRIG;
`ifdef TRIG_AUTO_EN
                            auto_cnt_q <= AUTO_LD;
`endif
                        end
                    end
                end
                S_WAIT_TRIG: begin
                    if (trig) begin
                        // Trigger sample is written at wp_q this cycle.
                        ra_q       <= wp_q - PRE_A;
                        post_cnt_q <= POST_A;
                        rd_cnt_q   <= LEN_C;
                        forced_q   <= auto_hit && !cross_hit;
                        state_q    <= (POST == 0) ? S_READOUT : S_POSTFILL;
                    end
`ifdef TRIG_AUTO_EN
                    else if (in_valid && auto_en) begin
                        auto_cnt_q <= auto_cnt_q - AUTO_ONE;
                    end
`endif
                end
                S_POSTFILL: begin
                    if (in_valid) begin
                        post_cnt_q <= post_cnt_q - A_ONE;
                        if (post_cnt_q == A_ONE) begin
                            state_q <= S_READOUT;
                        end
                    end
                end
                S_READOUT: begin
                    if (out_fire && out_last_q) begin
                        if (arm) begin
                            state_q   <= S_PREFILL;
                            pre_cnt_q <= PRE_A;
                            forced_q  <= 1'b0;
                        end else begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;
    assign forced    = forced_q;

endmodule

// File: tb/tb_adc_trigger.sv
module tb_adc_trigger;

    localparam int DN      = 10;
    localparam int ABITS   = 4;
    localparam int LEN     = 16;
    localparam int PRE     = 4;
    localparam int AUTO_TO = 50;

    logic          clk;
    logic          n_reset;
    logic [DN-1:0] in_data;
    logic          in_valid;
    logic [DN-1:0] level;
    logic          edge_sel;
    logic          auto_en;
    logic          arm;
    logic [DN-1:0] out_data;
    logic          out_valid;
    logic          out_last;
    logic          out_ready;
    logic          busy;
    logic          forced;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [DN-1:0] d;
        logic          l;
    } exp_t;
    exp_t exp_q[$];

    logic          gen_en   = 1'b0;
    logic [DN-1:0] gen_val  = '0;
    int            gen_step = 1;
    int            vdiv     = 1;
    int            phase    = 0;

    adc_trigger #(
        .DN(DN), .ABITS(ABITS), .PRE(PRE), .AUTO_TO(AUTO_TO)
    ) dut (
        .clkADC   (clk),
        .n_reset  (n_reset),
        .in_data  (in_data),
        .in_valid (in_valid),
        .level    (level),
        .edge_sel (edge_sel),
        .auto_en  (auto_en),
        .arm      (arm),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_last (out_last),
        .out_ready(out_ready),
        .busy     (busy),
        .forced   (forced)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Sample source: ramp/constant, one valid sample every vdiv cycles,
    // junk data on the idle cycles.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (gen_en) begin
                phase = (phase + 1 >= vdiv) ? 0 : phase + 1;
                if (phase == 0) begin
                    in_valid = 1'b1;
                    in_data  = gen_val;
                    gen_val  = gen_val + DN'(gen_step);
                end else begin
                    in_valid = 1'b0;
                    in_data  = DN'($urandom);
                end
            end else begin
                in_valid = 1'b0;
            end
        end
    end

    task automatic push_frame(input int first, input int step);
        exp_t e;
        for (int i = 0; i < LEN; i++) begin
            e.d = DN'(first + step * i);
            e.l = (i == LEN - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic start_source(input int start, input int step, input int div);
        gen_val  = DN'(start);
        gen_step = step;
        vdiv     = div;
        phase    = 0;
        gen_en   = 1'b1;
    endtask

    task automatic test_reset;
        n_reset = 1'b1;
        #1 n_reset = 1'b0;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        checks++; if (out_last !== 1'b0) begin failures++; $display("FAIL reset_out_last got=%b want=0", out_last); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
        checks++; if (forced !== 1'b0) begin failures++; $display("FAIL reset_forced got=%b want=0", forced); end
        checks++; if (out_data !== '0) begin failures++; $display("FAIL reset_out_data got=%0d want=0", out_data); end
        @(negedge clk);
        n_reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_ramp_frame(input string name, input int start, input int step,
                                   input int div, input int lvl, input logic edg, input int first);
        exp_t e;
        int   cyc;
        @(negedge clk);
        level     = DN'(lvl);
        edge_sel  = edg;
        out_ready = 1'b1;
        start_source(start, step, div);
        push_frame(first, step);
        arm = 1'b1;
        @(negedge clk);
        arm = 1'b0;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL %s busy_after_arm got=%b want=1", name, busy); end
        cyc = 0;
        while (exp_q.size() > 0 && cyc < 2000) begin
            if (out_valid && out_ready) begin
                e = exp_q.pop_front();
                checks++; if (out_data !== e.d) begin failures++; $display("FAIL %s data got=%0d want=%0d", name, out_data, e.d); end
                checks++; if (out_last !== e.l) begin failures++; $display("FAIL %s last got=%b want=%b (data %0d)", name, out_last, e.l, e.d); end
            end
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s timeout beats_missing=%0d want=0", name, exp_q.size());
            exp_q.delete();
        end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL %s busy_end got=%b want=0", name, busy); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL %s valid_end got=%b want=0", name, out_valid); end
        gen_en = 1'b0;
    endtask

    task automatic test_backpressure;
        exp_t          e;
        int            cyc;
        logic          stalled;
        logic [DN-1:0] held;
        @(negedge clk);
        level    = DN'(100);
        edge_sel = 1'b0;
        start_source(0, 1, 1);
        push_frame(96, 1);
        arm = 1'b1;
        @(negedge clk);
        arm     = 1'b0;
        stalled = 1'b0;
        held    = '0;
        cyc     = 0;
        while (exp_q.size() > 0 && cyc < 2000) begin
            out_ready = (cyc % 3 == 0);
            if (stalled) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== held) begin
                    failures++;
                    $display("FAIL bp_stall_hold got=%b/%0d want=1/%0d", out_valid, out_data, held);
                end
            end
            if (out_valid && out_ready) begin
                e = exp_q.pop_front();
                checks++; if (out_data !== e.d) begin failures++; $display("FAIL bp_data got=%0d want=%0d", out_data, e.d); end
                checks++; if (out_last !== e.l) begin failures++; $display("FAIL bp_last got=%b want=%b", out_last, e.l); end
            end
            stalled = out_valid && !out_ready;
            held    = out_data;
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL bp_timeout beats_missing=%0d want=0", exp_q.size());
            exp_q.delete();
        end
        out_ready = 1'b1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL bp_busy_end got=%b want=0", busy); end
        gen_en = 1'b0;
    endtask

    task automatic test_back_to_back;
        exp_t e;
        int   cyc;
        logic chk_busy;
        @(negedge clk);
        level     = DN'(100);
        edge_sel  = 1'b0;
        out_ready = 1'b1;
        start_source(0, 1, 1);
        push_frame(96, 1);
        push_frame(96, 1);
        arm      = 1'b1;
        chk_busy = 1'b0;
        cyc      = 0;
        while (exp_q.size() > 0 && cyc < 3000) begin
            if (chk_busy) begin
                checks++; if (busy !== 1'b1) begin failures++; $display("FAIL b2b_rearm_busy got=%b want=1", busy); end
                chk_busy = 1'b0;
            end
            if (out_valid && out_ready) begin
                e = exp_q.pop_front();
                checks++; if (out_data !== e.d) begin failures++; $display("FAIL b2b_data got=%0d want=%0d", out_data, e.d); end
                checks++; if (out_last !== e.l) begin failures++; $display("FAIL b2b_last got=%b want=%b", out_last, e.l); end
                if (e.l && exp_q.size() > 0) chk_busy = 1'b1;
                if (exp_q.size() == 0) arm = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        arm = 1'b0;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL b2b_timeout beats_missing=%0d want=0", exp_q.size());
            exp_q.delete();
        end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL b2b_busy_end got=%b want=0", busy); end
        gen_en = 1'b0;
    endtask

    task automatic test_no_trigger(input string name, input int start, input int step,
                                   input int lvl, input logic edg, input logic aen);
        int seen;
        @(negedge clk);
        level    = DN'(lvl);
        edge_sel = edg;
        auto_en  = aen;
        start_source(start, step, 1);
        arm = 1'b1;
        @(negedge clk);
        arm  = 1'b0;
        seen = 0;
        for (int c = 0; c < 1100; c++) begin
            if (out_valid) seen++;
            @(negedge clk);
        end
        checks++; if (seen != 0) begin failures++; $display("FAIL %s valid_beats got=%0d want=0", name, seen); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL %s busy_waiting got=%b want=1", name, busy); end
        checks++; if (forced !== 1'b0) begin failures++; $display("FAIL %s forced got=%b want=0", name, forced); end
        gen_en  = 1'b0;
        n_reset = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL %s busy_in_reset got=%b want=0", name, busy); end
        n_reset = 1'b1;
        auto_en = 1'b0;
        @(negedge clk);
    endtask

`ifdef TRIG_AUTO_EN
    task automatic test_auto;
        exp_t e;
        int   cyc;
        @(negedge clk);
        level     = DN'(100);
        edge_sel  = 1'b0;
        auto_en   = 1'b1;
        out_ready = 1'b1;
        start_source(5, 0, 1);
        push_frame(5, 0);
        arm = 1'b1;
        @(negedge clk);
        arm = 1'b0;
        cyc = 0;
        while (exp_q.size() > 0 && cyc < 2000) begin
            if (out_valid && out_ready) begin
                e = exp_q.pop_front();
                checks++; if (out_data !== e.d) begin failures++; $display("FAIL auto_data got=%0d want=%0d", out_data, e.d); end
                checks++; if (out_last !== e.l) begin failures++; $display("FAIL auto_last got=%b want=%b", out_last, e.l); end
            end
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL auto_timeout beats_missing=%0d want=0", exp_q.size());
            exp_q.delete();
        end
        checks++; if (forced !== 1'b1) begin failures++; $display("FAIL auto_forced got=%b want=1", forced); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL auto_busy_end got=%b want=0", busy); end
        auto_en = 1'b0;
        gen_en  = 1'b0;
    endtask
`else
    task automatic test_auto;
        test_no_trigger("auto_off", 5, 0, 100, 1'b0, 1'b1);
    endtask
`endif

    initial begin
        in_data   = '0;
        in_valid  = 1'b0;
        level     = '0;
        edge_sel  = 1'b0;
        auto_en   = 1'b0;
        arm       = 1'b0;
        out_ready = 1'b1;
        test_reset();
        test_ramp_frame("rise", 0, 1, 1, 100, 1'b0, 96);
        test_ramp_frame("sparse", 0, 1, 3, 100, 1'b0, 96);
        test_ramp_frame("fall", 1023, -1, 1, 900, 1'b1, 904);
        test_backpressure();
        test_back_to_back();
        test_no_trigger("rise_lvl0", 0, 1, 0, 1'b0, 1'b0);
        test_no_trigger("fall_lvlmax", 1023, -1, 1023, 1'b1, 1'b0);
        test_auto();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
